// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants for the machine-mode CSR sequencer: addresses, MSTATUS fields,
// instruction op encodings and FSM states.
package csr_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  typedef enum logic [1:0] {
    OP_RO = 2'b00,
    OP_RW = 2'b01,
    OP_RS = 2'b10,
    OP_RC = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_STAT, S_T_VEC, S_M_STAT, S_M_EPC
  } state_e;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write for CSR instructions plus the MSTATUS
// updates applied on trap entry and MRET.
module csr_rmw_alu
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] inst_val,
  output logic [XLEN-1:0] trap_stat,
  output logic [XLEN-1:0] mret_stat
);

  always_comb begin
    case (csr_op_e'(op))
      OP_RW:   inst_val = operand;
      OP_RS:   inst_val = old | operand;
      OP_RC:   inst_val = old & ~operand;
      default: inst_val = old;
    endcase

    trap_stat                = old;
    trap_stat[MPIE_BIT]      = old[MIE_BIT];
    trap_stat[MIE_BIT]       = 1'b0;
    trap_stat[MPP_HI:MPP_LO] = 2'b11;

    mret_stat                = old;
    mret_stat[MIE_BIT]       = old[MPIE_BIT];
    mret_stat[MPIE_BIT]      = 1'b1;
    mret_stat[MPP_HI:MPP_LO] = 2'b11;
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Arbiter/sequencer for the single-port M-mode CSR file: CSR instructions,
// multi-cycle trap entry and MRET, each sequence ending in a fetch redirect.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [1:0]      inst_op,
  input  logic [11:0]     inst_addr,
  input  logic [XLEN-1:0] inst_wdata,
  input  logic            inst_wen,
  output logic [XLEN-1:0] inst_rdata,
  output logic            inst_illegal,
  input  logic            trap_req,
  output logic            trap_ready,
  input  logic            trap_irq,
  input  logic [4:0]      trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  output logic            mret_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_we,
  input  logic [XLEN-1:0] csr_rdata
);

  state_e          state, state_nxt;
  logic            irq_q;
  logic [4:0]      cause_q;
  logic [XLEN-1:0] pc_q, tval_q;
  logic [XLEN-1:0] inst_val, trap_stat, mret_stat, vec_off;
  logic            inst_impl;

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .op        (inst_op),
    .old       (csr_rdata),
    .operand   (inst_wdata),
    .inst_val  (inst_val),
    .trap_stat (trap_stat),
    .mret_stat (mret_stat)
  );

  assign inst_impl = csr_implemented(inst_addr);
  assign vec_off   = {{(XLEN-7){1'b0}}, cause_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Trap operands are captured on acceptance so the requester may drop them.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= 1'b0;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else if (state == S_IDLE && trap_req) begin
      irq_q   <= trap_irq;
      cause_q <= trap_cause;
      pc_q    <= trap_pc;
      tval_q  <= trap_tval;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trap_req)      state_nxt = S_T_EPC;
        else if (mret_req) state_nxt = S_M_STAT;
      end
      S_T_EPC:   state_nxt = S_T_CAUSE;
      S_T_CAUSE: state_nxt = S_T_TVAL;
      S_T_TVAL:  state_nxt = S_T_STAT;
      S_T_STAT:  state_nxt = S_T_VEC;
      S_M_STAT:  state_nxt = S_M_EPC;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so nothing leaks during reset.
  always_comb begin
    inst_ready     = 1'b0;
    inst_rdata     = '0;
    inst_illegal   = 1'b0;
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    csr_we         = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: begin
          trap_ready = trap_req;
          mret_ready = mret_req & ~trap_req;
          inst_ready = inst_valid & ~trap_req & ~mret_req;
          if (inst_ready) begin
            csr_addr     = inst_addr;
            inst_illegal = ~inst_impl;
            inst_rdata   = inst_impl ? csr_rdata : '0;
            csr_wdata    = inst_val;
            csr_we       = inst_wen & (inst_op != OP_RO) & inst_impl;
          end
        end
        S_T_EPC: begin
          csr_addr  = CSR_MEPC;
          csr_wdata = pc_q;
          csr_we    = 1'b1;
        end
        S_T_CAUSE: begin
          csr_addr  = CSR_MCAUSE;
          csr_wdata = {irq_q, {(XLEN-6){1'b0}}, cause_q};
          csr_we    = 1'b1;
        end
        S_T_TVAL: begin
          csr_addr  = CSR_MTVAL;
          csr_wdata = tval_q;
          csr_we    = 1'b1;
        end
        S_T_STAT: begin
          csr_addr  = CSR_MSTATUS;
          csr_wdata = trap_stat;
          csr_we    = 1'b1;
        end
        S_T_VEC: begin
          // Only mode 01 vectors, and only for interrupts; 10/11 behave as direct.
          csr_addr       = CSR_MTVEC;
          redirect_valid = 1'b1;
          redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00}
                         + ((csr_rdata[1:0] == 2'b01 && irq_q) ? vec_off : '0);
        end
        S_M_STAT: begin
          csr_addr  = CSR_MSTATUS;
          csr_wdata = mret_stat;
          csr_we    = 1'b1;
        end
        S_M_EPC: begin
          csr_addr       = CSR_MEPC;
          redirect_valid = 1'b1;
          redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Sequencer and arbiter for the single-port machine-mode CSR file (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MSCRATCH 0x340, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343, MIP 0x344).
- Shares the one addr/wdata/we port between three requesters: pipeline CSR instructions, trap entry and MRET.
- Trap entry and MRET are multi-cycle write sequences that end with a PC redirect to fetch.
- The CSR file read is combinational (rdata valid in the same cycle as addr); writes take effect at the next clk edge.

Parameters:
XLEN, 32, data width of the CSRs and the PC.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_valid  in  1  CSR instruction request
- inst_ready  out  1  instruction accepted/completed this cycle
- inst_op  in  2  01 RW, 10 RS, 11 RC, 00 read-only
- inst_addr  in  12  CSR address
- inst_wdata  in  XLEN  rs1/zimm operand
- inst_wen  in  1  0 suppresses the write (rs1 = x0 case)
- inst_rdata  out  XLEN  old CSR value
- inst_illegal  out  1  unimplemented address
- trap_req  in  1  trap request, held until trap_ready
- trap_ready  out  1  trap accepted
- trap_irq  in  1  1 = interrupt
- trap_cause  in  5  cause code
- trap_pc  in  XLEN  faulting PC, goes to MEPC
- trap_tval  in  XLEN  goes to MTVAL
- mret_req  in  1  MRET request, held until mret_ready
- mret_ready  out  1  MRET accepted
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  XLEN  new fetch PC
- busy  out  1  FSM not in IDLE
- csr_addr  out  12  to CSR file
- csr_wdata  out  XLEN  to CSR file
- csr_we  out  1  to CSR file
- csr_rdata  in  XLEN  from CSR file

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: FSM goes to IDLE; all outputs read 0 (busy, redirect_valid, ready signals, csr_we, csr_addr, csr_wdata, inst_rdata, inst_illegal).
- Arbitration in IDLE, fixed priority trap > mret > inst.
  - trap_ready = IDLE & trap_req.
  - mret_ready = IDLE & mret_req & !trap_req.
  - inst_ready = IDLE & inst_valid & !trap_req & !mret_req.
  - A requester that loses holds its request; no request is dropped.
- Instruction op (1 cycle, in IDLE):
  - csr_addr = inst_addr; inst_rdata = csr_rdata (combinational).
  - New value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
  - csr_we = inst_ready & inst_wen & (op != 00) & implemented(inst_addr).
  - Unimplemented address: inst_illegal = 1, inst_rdata = 0, no write. inst_ready still asserts.
- Trap sequence: on acceptance, latch irq, cause, pc and tval into registers. Then one state per cycle:
  - T_EPC: write 0x341 = pc_q.
  - T_CAUSE: write 0x342 = {irq_q, zeros, cause_q} (irq in bit XLEN-1, cause in bits [4:0]).
  - T_TVAL: write 0x343 = tval_q.
  - T_STAT: read 0x300, write back with MPIE(7) = old MIE(3), MIE(3) = 0, MPP[12:11] = 2'b11, all other bits unchanged.
  - T_VEC: read 0x305, no write. redirect_valid = 1.
    - redirect_pc = {mtvec[XLEN-1:2], 2'b00} + (mtvec[1:0] == 2'b01 && irq_q ? cause_q << 2 : 0).
    - Mode values 10/11 are treated as direct.
  - Then return to IDLE.
  - Latency: acceptance edge plus 5 cycles; redirect pulses in the 5th busy cycle.
- MRET sequence:
  - M_STAT: read 0x300, write MIE(3) = old MPIE(7), MPIE = 1, MPP = 2'b11.
  - M_EPC: read 0x341, redirect_valid = 1, redirect_pc = {mepc[XLEN-1:2], 2'b00}.
  - Then IDLE.
- busy = 1 in every non-IDLE state; no request is accepted while busy.
- Requests deasserted mid-sequence have no effect; a latched sequence always completes.
- Reset mid-sequence: return to IDLE immediately. Writes already issued remain in the CSR file; no redirect is issued.
- Arithmetic wraps modulo 2^XLEN.

Decomposition:
- Shared package: CSR address constants (0x300..0x344), MSTATUS bit indices (MIE = 3, MPIE = 7, MPP = 12:11), inst_op encodings, FSM state encodings.
- One sub-module: csr_rmw_alu (combinational RW/RS/RC and the MSTATUS trap/MRET update functions).
- The FSM and arbitration stay in the top level.

Test Plan:
- Reset, then inst RS to 0x304: wdata 0x888, CSR 0x0 -> inst_rdata 0x0, csr_we = 1, csr_wdata 0x888, inst_ready in the same cycle.
- inst RC to 0x300: old 0x88, wdata 0x08 -> csr_wdata 0x80. Same op with inst_wen = 0 -> csr_we = 0. Address 0x7C0 -> inst_illegal = 1, no write.
- Trap: irq = 0, cause = 2, pc 0x100, tval 0xDEAD, mtvec 0x2000, mstatus 0x8 -> writes 0x341 = 0x100, 0x342 = 0x2, 0x343 = 0xDEAD, 0x300 = 0x1880; redirect_pc 0x2000 in the 5th cycle.
- Vectored interrupt: mtvec 0x2001, irq = 1, cause = 7 -> MCAUSE 0x80000007, redirect_pc 0x201C.
- MRET: mstatus 0x1880, mepc 0x104 -> mstatus written 0x1888, redirect_pc 0x104 two cycles after acceptance.
- trap_req, mret_req and inst_valid in the same cycle -> only trap_ready asserts; mret is accepted on the first IDLE cycle after the trap, inst after mret. rst asserted in T_CAUSE -> IDLE next cycle, MEPC already written, no redirect.
